// File: rtl/pipe_mem_responder.sv
// Dual-read, single-write 16-bit memory that self-clears after reset.
// Reads have a fixed two-cycle latency with write-first forwarding.
module pipe_mem_responder #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] raddr0,
    output logic [15:0] rdata0,
    input  logic [15:0] raddr1,
    output logic [15:0] rdata1,
    input  logic        wen,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    output logic        ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_sweep;
    logic [DEPTH_LOG2-1:0] w_sweep_nxt;

    logic [15:0]           r_mem [DEPTH];

    logic                  r_v_s1;
    logic [DEPTH_LOG2-1:0] r_a0_s1;
    logic [DEPTH_LOG2-1:0] r_a1_s1;
    logic [15:0]           r_rdata0;
    logic [15:0]           r_rdata1;

    logic                  w_run;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_wa;
    logic [DEPTH_LOG2-1:0] w_ra0;
    logic [DEPTH_LOG2-1:0] w_ra1;
    logic [15:0]           w_d0;
    logic [15:0]           w_d1;
    logic                  w_unused;

    assign w_run = (r_state == S_RUN);
    assign w_we  = wen && w_run;
    assign w_wa  = waddr[DEPTH_LOG2-1:0];
    assign w_ra0 = raddr0[DEPTH_LOG2-1:0];
    assign w_ra1 = raddr1[DEPTH_LOG2-1:0];

    assign w_unused = ^{raddr0[15:DEPTH_LOG2],
                        raddr1[15:DEPTH_LOG2],
                        waddr[15:DEPTH_LOG2]};

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        unique case (r_state)
            S_CLEAR: begin
                w_sweep_nxt = r_sweep + 1'b1;
                if (&r_sweep) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_sweep_nxt = r_sweep;
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    // The older in-flight write is already in r_mem when stage 2
    // looks up; only the write of this same cycle needs forwarding.
    always_comb begin
        w_d0 = r_mem[r_a0_s1];
        w_d1 = r_mem[r_a1_s1];
        if (w_we && (w_wa == r_a0_s1)) begin
            w_d0 = wdata;
        end
        if (w_we && (w_wa == r_a1_s1)) begin
            w_d1 = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_CLEAR;
            r_sweep  <= '0;
            r_v_s1   <= 1'b0;
            r_a0_s1  <= '0;
            r_a1_s1  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sweep  <= w_sweep_nxt;
            r_v_s1   <= w_run;
            r_a0_s1  <= w_ra0;
            r_a1_s1  <= w_ra1;
            r_rdata0 <= r_v_s1 ? w_d0 : 16'h0000;
            r_rdata1 <= r_v_s1 ? w_d1 : 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_sweep] <= 16'h0000;
            end else if (w_we) begin
                r_mem[w_wa] <= wdata;
            end
        end
    end

    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
    assign ready  = w_run;

endmodule

// File: tb/tb_pipe_mem_responder.sv
// Randomized bench for pipe_mem_responder against a cycle-level
// model of storage contents, clear timing and read latency.
module tb_pipe_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wen = 1'b0;
    logic [15:0] raddr0 = '0;
    logic [15:0] raddr1 = '0;
    logic [15:0] waddr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata0;
    logic [15:0] rdata1;
    logic        ready;

    pipe_mem_responder #(.DEPTH_LOG2(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .raddr0 (raddr0),
        .rdata0 (rdata0),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .ready  (ready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] ref_mem [256];
    bit          m_run = 1'b0;
    int          m_cnt = 0;
    bit          started = 1'b0;
    int          k = 0;

    bit          h_rst [4];
    bit          h_run [4];
    logic [15:0] h_a0  [4];
    logic [15:0] h_a1  [4];

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, k);
        end
    endtask

    // Drives one cycle, advances past its edge, updates the model
    // and checks the outputs of the following cycle.
    task automatic cycle(input bit rst, input bit we,
                         input logic [15:0] wa, input logic [15:0] wd,
                         input logic [15:0] a0, input logic [15:0] a1);
        int i;
        int p;
        int q;
        logic [15:0] e0;
        logic [15:0] e1;
        reset  = rst;
        wen    = we;
        waddr  = wa;
        wdata  = wd;
        raddr0 = a0;
        raddr1 = a1;
        i = k % 4;
        h_rst[i] = rst;
        h_run[i] = m_run;
        h_a0[i]  = a0;
        h_a1[i]  = a1;
        @(posedge clk);
        #1;
        k++;
        if (rst) begin
            m_run = 1'b0;
            m_cnt = 0;
            foreach (ref_mem[j]) ref_mem[j] = 16'h0000;
            started = 1'b1;
        end else if (m_run) begin
            if (we) ref_mem[wa[7:0]] = wd;
        end else if (m_cnt == 255) begin
            m_run = 1'b1;
        end else begin
            m_cnt++;
        end
        if (started) begin
            e0 = 16'h0000;
            e1 = 16'h0000;
            if (k >= 2) begin
                p = (k - 2) % 4;
                q = (k - 1) % 4;
                if (h_run[p] && !h_rst[p] && !h_rst[q]) begin
                    e0 = ref_mem[h_a0[p][7:0]];
                    e1 = ref_mem[h_a1[p][7:0]];
                end
            end
            chk("ready", {15'b0, ready}, {15'b0, m_run});
            chk("rdata0", rdata0, e0);
            chk("rdata1", rdata1, e1);
        end
    endtask

    task automatic idle(input logic [15:0] a0, input logic [15:0] a1);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, a0, a1);
    endtask

    task automatic wr(input logic [15:0] wa, input logic [15:0] wd,
                      input logic [15:0] a0, input logic [15:0] a1);
        cycle(1'b0, 1'b1, wa, wd, a0, a1);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 1000) begin
            idle(16'($urandom()), 16'($urandom()));
            n++;
        end
        chk(tag, 16'(n), 16'd256);
    endtask

    task automatic read_all;
        for (int i = 0; i < 258; i++) begin
            idle(16'(i & 255), 16'(255 - (i & 255)));
        end
    endtask

    task automatic rand_cycles(input int n);
        logic [15:0] m;
        m = 16'hFF07;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)),
                  16'($urandom()) & m, 16'($urandom()),
                  16'($urandom()) & m, 16'($urandom()) & m);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 16'h0001, 16'hFFFF, 16'h0, 16'h0);
        end
        wait_ready("ready_lat");
        read_all();

        wr(16'h0005, 16'h1234, 16'h0005, 16'h0105);
        idle(16'h0, 16'h0);
        chk("bypass_same0", rdata0, 16'h1234);
        chk("bypass_same1", rdata1, 16'h1234);

        wr(16'h0007, 16'hAAAA, 16'h0000, 16'h0007);
        wr(16'h0007, 16'hBEEF, 16'h0000, 16'h0000);
        chk("bypass_newer", rdata1, 16'hBEEF);

        wr(16'h0103, 16'h0042, 16'h0000, 16'h0000);
        idle(16'h0003, 16'hFF03);
        idle(16'h0000, 16'h0000);
        chk("wrap0", rdata0, 16'h0042);
        chk("wrap1", rdata1, 16'h0042);

        for (int i = 0; i < 16; i++) begin
            wr(16'(i), 16'(i * 3), 16'h0, 16'h0);
        end
        for (int i = 0; i < 18; i++) begin
            idle(16'(i < 16 ? i : 0), 16'(i < 16 ? i : 0));
            if (i >= 1 && i <= 16) begin
                chk("stream0", rdata0, 16'((i - 1) * 3));
                chk("stream1", rdata1, 16'((i - 1) * 3));
            end
        end

        rand_cycles(1500);

        wr(16'h0009, 16'h5555, 16'h0, 16'h0);
        cycle(1'b1, 1'b1, 16'h0009, 16'hDEAD, 16'h0009, 16'h0009);
        chk("rst_ready", {15'b0, ready}, 16'h0000);
        chk("rst_rdata0", rdata0, 16'h0000);
        wait_ready("ready_lat2");
        idle(16'h0009, 16'h0109);
        idle(16'h0000, 16'h0000);
        idle(16'h0000, 16'h0000);
        chk("rst_nowrite0", rdata0, 16'h0000);
        chk("rst_nowrite1", rdata1, 16'h0000);
        read_all();

        rand_cycles(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
